// File: rtl/shared_out_arbiter.sv
// Round-robin ownership arbiter for one shared output register; only the granted requester may write it.
// Grant 1 cycle after a request is seen in IDLE; an accepted write appears on out (with out_vld) 1 cycle later.
// No backpressure: requests wait at level until granted, non-owner writes/releases are dropped.
// Optional build macro ARB_TIMEOUT_EN: revoke a grant after TIMEOUT owned cycles and pulse timeout_err.
module shared_out_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 1,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         rel,
    input  logic [N_REQ-1:0]         wr_en,
    input  logic [N_REQ*DW-1:0]      wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic [DW-1:0]            out,
    output logic                     out_vld,
    output logic                     timeout_err
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   scan_idx;
    logic            own_req;
    logic            own_rel;
    logic            own_wr;
    logic [DW-1:0]   own_dat;
    logic            grant_now;
    logic            write_now;
    logic            rel_now;
    logic            to_now;
    logic            drop;

    // Round-robin search: first active request strictly after the last owner, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = IW'((int'(rr_ptr) + k) % N_REQ);
            if (!pick_vld && req[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    // Route the current owner's request, release, write strobe and data.
    always_comb begin
        own_req = 1'b0;
        own_rel = 1'b0;
        own_wr  = 1'b0;
        own_dat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == IW'(i)) begin
                own_req = req[i];
                own_rel = rel[i];
                own_wr  = wr_en[i];
                own_dat = wdata[i*DW +: DW];
            end
        end
    end

    assign grant_now = (state == S_IDLE) && pick_vld;
    assign write_now = (state == S_OWNED) && own_wr;
    assign rel_now   = (state == S_OWNED) && (own_rel || !own_req);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    // hold_cnt is the number of owned cycles already completed, so the
    // TIMEOUT-th owned cycle is the one where it reads TIMEOUT-1.
    logic [CW-1:0] hold_cnt;

    // Hold counter: cleared while idle (i.e. on entry to OWNED), counts owned cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state == S_OWNED) begin
            hold_cnt <= hold_cnt + 1'b1;
        end else begin
            hold_cnt <= '0;
        end
    end

    // A release in the expiry cycle wins over the timeout.
    assign to_now = (state == S_OWNED) && !rel_now && (hold_cnt == CW'(TIMEOUT - 1));

    // Timeout error pulse on the edge that revokes the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= to_now;
        end
    end
`else
    assign to_now      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign drop = rel_now || to_now;

    // State: IDLE -> OWNED on a pick, OWNED -> IDLE on release or timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state <= grant_now ? S_OWNED : S_IDLE;
                S_OWNED: state <= drop ? S_IDLE : S_OWNED;
                default: state <= S_IDLE;
            endcase
        end
    end

    // One-hot grant: set on pick, cleared when ownership ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt <= '0;
        end else if (grant_now) begin
            gnt <= N_REQ'(1) << pick_idx;
        end else if ((state == S_OWNED) && drop) begin
            gnt <= '0;
        end else begin
            gnt <= gnt;
        end
    end

    // Owner index latched at grant time; left unchanged after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= '0;
        end else if (grant_now) begin
            owner <= pick_idx;
        end else begin
            owner <= owner;
        end
    end

    // Round-robin pointer remembers the last owner so it ranks lowest next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= IW'(N_REQ - 1);
        end else if ((state == S_OWNED) && drop) begin
            rr_ptr <= owner;
        end else begin
            rr_ptr <= rr_ptr;
        end
    end

    // Shared output register: only the owner's write lands, even on its release cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else if (write_now) begin
            out <= own_dat;
        end else begin
            out <= out;
        end
    end

    // Write-accepted pulse, aligned with the updated out value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
        end else begin
            out_vld <= write_now;
        end
    end

endmodule
